// File: rtl/cp0_reg_if.sv
// Bus between the memory-stage pipeline and the CP0 register file:
// mtc0/mfc0 access, interrupt lines, exception info and redirect results.
interface cp0_reg_if;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] rdata_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;
  logic        timer_int_o;
  logic        flush_o;
  logic [31:0] newpc_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr_i, int_i, excepttype_i, pc_i,
           in_delayslot_i, bad_addr_i,
    input  rdata_o, status_o, cause_o, epc_o, timer_int_o, flush_o, newpc_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr_i, int_i, excepttype_i, pc_i,
           in_delayslot_i, bad_addr_i,
    output rdata_o, status_o, cause_o, epc_o, timer_int_o, flush_o, newpc_o
  );
endinterface

// File: rtl/cp0_reg.sv
// MIPS-32 coprocessor-0 register file: Status/Cause/EPC/BadVAddr update on
// exceptions, mtc0/mfc0 access, Count/Compare timer and pipeline redirect.
module cp0_reg #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter logic [31:0] PRID_VALUE   = 32'h00004220,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input logic      clk,
  input logic      rst,
  cp0_reg_if.slave bus
);
  localparam logic [31:0] STATUS_RST   = 32'h00400000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;
  localparam logic [4:0]  A_BADVADDR   = 5'd8;
  localparam logic [4:0]  A_COUNT      = 5'd9;
  localparam logic [4:0]  A_COMPARE    = 5'd11;
  localparam logic [4:0]  A_STATUS     = 5'd12;
  localparam logic [4:0]  A_CAUSE      = 5'd13;
  localparam logic [4:0]  A_EPC        = 5'd14;
  localparam logic [4:0]  A_PRID       = 5'd15;
  localparam logic [4:0]  A_CONFIG     = 5'd16;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q;
  logic        timer_int_q, timer_int_d;
  logic        is_exc, is_addr_exc, is_eret;
  logic [4:0]  exc_code;

  // Only the listed codes raise an exception; any other nonzero value is dropped.
  always_comb begin
    is_exc      = 1'b0;
    is_addr_exc = 1'b0;
    case (bus.excepttype_i)
      32'h01, 32'h08, 32'h09, 32'h0a, 32'h0c: is_exc = 1'b1;
      32'h04, 32'h05: begin
        is_exc      = 1'b1;
        is_addr_exc = 1'b1;
      end
      default: ;
    endcase
  end

  assign is_eret  = (bus.excepttype_i == 32'h0000000e);
  assign exc_code = (bus.excepttype_i == 32'h00000001) ? 5'd0 : bus.excepttype_i[4:0];

  always_comb begin
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    badvaddr_d  = badvaddr_q;
    compare_d   = compare_q;
    count_d     = tick_q ? count_q + 32'd1 : count_q;
    timer_int_d = timer_int_q | ((count_q == compare_q) && (compare_q != 32'd0));
    cause_d[15:10] = bus.int_i;
    cause_d[15]    = bus.int_i[5] | timer_int_q;
    if (bus.we_i) begin
      case (bus.waddr_i)
        A_COUNT:   count_d = bus.wdata_i;
        A_COMPARE: begin
          compare_d   = bus.wdata_i;
          timer_int_d = 1'b0;
        end
        A_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
        A_CAUSE:   cause_d[9:8] = bus.wdata_i[9:8];
        A_EPC:     epc_d = bus.wdata_i;
        default: ;
      endcase
    end
    // Exception fields are applied after the mtc0 write so they win on overlap.
    if (is_exc) begin
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc_code;
      if (!status_q[1]) begin
        epc_d       = bus.in_delayslot_i ? bus.pc_i - 32'd4 : bus.pc_i;
        cause_d[31] = bus.in_delayslot_i;
      end
      if (is_addr_exc) badvaddr_d = bus.bad_addr_i;
    end else if (is_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q    <= STATUS_RST;
      cause_q     <= 32'd0;
      epc_q       <= 32'd0;
      badvaddr_q  <= 32'd0;
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      tick_q      <= 1'b0;
      timer_int_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      badvaddr_q  <= badvaddr_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      tick_q      <= ~tick_q;
      timer_int_q <= timer_int_d;
    end
  end

  always_comb begin
    case (bus.raddr_i)
      A_BADVADDR: bus.rdata_o = badvaddr_q;
      A_COUNT:    bus.rdata_o = count_q;
      A_COMPARE:  bus.rdata_o = compare_q;
      A_STATUS:   bus.rdata_o = status_q;
      A_CAUSE:    bus.rdata_o = cause_q;
      A_EPC:      bus.rdata_o = epc_q;
      A_PRID:     bus.rdata_o = PRID_VALUE;
      A_CONFIG:   bus.rdata_o = CONFIG_VALUE;
      default:    bus.rdata_o = 32'd0;
    endcase
  end

  // eret forwards a same-cycle mtc0 EPC write so the redirect sees the new value.
  always_comb begin
    bus.flush_o = is_exc | is_eret;
    if (is_exc)
      bus.newpc_o = EXC_VECTOR;
    else if (is_eret)
      bus.newpc_o = (bus.we_i && bus.waddr_i == A_EPC) ? bus.wdata_i : epc_q;
    else
      bus.newpc_o = 32'd0;
  end

  assign bus.status_o    = status_q;
  assign bus.cause_o     = cause_q;
  assign bus.epc_o       = epc_q;
  assign bus.timer_int_o = timer_int_q;
endmodule

// File: tb/tb_cp0_reg.sv
// Scenario bench for cp0_reg: expectations are queued when stimulus is driven
// and popped against the observed DUT outputs.
module tb_cp0_reg;
  localparam logic [31:0] EXC_VECTOR   = 32'hBFC00380;
  localparam logic [31:0] PRID_VALUE   = 32'h00004220;
  localparam logic [31:0] CONFIG_VALUE = 32'h00008000;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t        sb[$];
  logic [31:0] obs[$];

  cp0_reg_if bus();

  cp0_reg #(
    .EXC_VECTOR  (EXC_VECTOR),
    .PRID_VALUE  (PRID_VALUE),
    .CONFIG_VALUE(CONFIG_VALUE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.we_i           = 1'b0;
    bus.waddr_i        = 5'd0;
    bus.wdata_i        = 32'd0;
    bus.excepttype_i   = 32'd0;
    bus.pc_i           = 32'd0;
    bus.in_delayslot_i = 1'b0;
    bus.bad_addr_i     = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we_i = 1'b1; bus.waddr_i = a; bus.wdata_i = d;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    exp_t e;
    idle();
    bus.int_i = 6'd0;
    bus.raddr_i = 5'd15;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{name:"rst_status", exp:32'h00400000});
    sb.push_back('{name:"rst_cause", exp:32'd0});
    sb.push_back('{name:"rst_epc", exp:32'd0});
    sb.push_back('{name:"rst_flush", exp:32'd0});
    sb.push_back('{name:"rst_prid", exp:PRID_VALUE});
    sb.push_back('{name:"rst_timer", exp:32'd0});
    obs.push_back(bus.status_o); obs.push_back(bus.cause_o); obs.push_back(bus.epc_o);
    obs.push_back(32'(bus.flush_o)); obs.push_back(bus.rdata_o); obs.push_back(32'(bus.timer_int_o));
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_syscall();
    exp_t e;
    @(negedge clk);
    bus.excepttype_i = 32'h8; bus.pc_i = 32'hBFC00100; bus.in_delayslot_i = 1'b0;
    sb.push_back('{name:"sys_flush", exp:32'd1});
    sb.push_back('{name:"sys_newpc", exp:EXC_VECTOR});
    #1;
    obs.push_back(32'(bus.flush_o)); obs.push_back(bus.newpc_o);
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
    sb.push_back('{name:"sys_epc", exp:32'hBFC00100});
    sb.push_back('{name:"sys_exccode", exp:32'd8});
    sb.push_back('{name:"sys_exl", exp:32'd1});
    sb.push_back('{name:"sys_bd", exp:32'd0});
    sb.push_back('{name:"sys_flush_after", exp:32'd0});
    @(posedge clk); #1;
    idle();
    #1;
    obs.push_back(bus.epc_o); obs.push_back(32'(bus.cause_o[6:2])); obs.push_back(32'(bus.status_o[1]));
    obs.push_back(32'(bus.cause_o[31])); obs.push_back(32'(bus.flush_o));
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
    mtc0(5'd12, 32'd0);
    sb.push_back('{name:"exl_clear_status", exp:32'h00400000});
    obs.push_back(bus.status_o);
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
  endtask

  task automatic test_adel_delayslot();
    exp_t e;
    @(negedge clk);
    bus.excepttype_i = 32'h4; bus.pc_i = 32'h80000010; bus.in_delayslot_i = 1'b1;
    bus.bad_addr_i = 32'h80001001; bus.raddr_i = 5'd8;
    sb.push_back('{name:"adel_epc", exp:32'h8000000C});
    sb.push_back('{name:"adel_bd", exp:32'd1});
    sb.push_back('{name:"adel_badvaddr", exp:32'h80001001});
    sb.push_back('{name:"adel_exccode", exp:32'd4});
    @(posedge clk); #1;
    idle();
    obs.push_back(bus.epc_o); obs.push_back(32'(bus.cause_o[31]));
    obs.push_back(bus.rdata_o); obs.push_back(32'(bus.cause_o[6:2]));
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
    // Nested exception while EXL=1 must not disturb EPC or BD.
    @(negedge clk);
    bus.excepttype_i = 32'hc; bus.pc_i = 32'h90000000; bus.in_delayslot_i = 1'b0;
    sb.push_back('{name:"nest_flush", exp:32'd1});
    sb.push_back('{name:"nest_newpc", exp:EXC_VECTOR});
    #1;
    obs.push_back(32'(bus.flush_o)); obs.push_back(bus.newpc_o);
    @(posedge clk); #1;
    idle();
    sb.push_back('{name:"nest_epc", exp:32'h8000000C});
    sb.push_back('{name:"nest_bd", exp:32'd1});
    sb.push_back('{name:"nest_exccode", exp:32'h0c});
    obs.push_back(bus.epc_o); obs.push_back(32'(bus.cause_o[31])); obs.push_back(32'(bus.cause_o[6:2]));
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
  endtask

  task automatic test_eret();
    exp_t e;
    @(negedge clk);
    bus.excepttype_i = 32'he; bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h80000200;
    sb.push_back('{name:"eret_fwd_flush", exp:32'd1});
    sb.push_back('{name:"eret_fwd_newpc", exp:32'h80000200});
    #1;
    obs.push_back(32'(bus.flush_o)); obs.push_back(bus.newpc_o);
    @(posedge clk); #1;
    idle();
    sb.push_back('{name:"eret_exl", exp:32'd0});
    sb.push_back('{name:"eret_epc", exp:32'h80000200});
    obs.push_back(32'(bus.status_o[1])); obs.push_back(bus.epc_o);
    @(negedge clk);
    bus.excepttype_i = 32'he;
    sb.push_back('{name:"eret_plain_newpc", exp:32'h80000200});
    #1;
    obs.push_back(bus.newpc_o);
    @(posedge clk); #1;
    idle();
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
  endtask

  task automatic test_ignored_and_int();
    exp_t e;
    logic [31:0] codes [2];
    codes[0] = 32'h00000002;
    codes[1] = 32'h00010008;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.excepttype_i = codes[i]; bus.pc_i = 32'h12345678;
      sb.push_back('{name:"ign_flush", exp:32'd0});
      sb.push_back('{name:"ign_newpc", exp:32'd0});
      #1;
      obs.push_back(32'(bus.flush_o)); obs.push_back(bus.newpc_o);
      @(posedge clk); #1;
      idle();
      sb.push_back('{name:"ign_epc", exp:32'h80000200});
      obs.push_back(bus.epc_o);
    end
    @(negedge clk);
    bus.excepttype_i = 32'h1; bus.pc_i = 32'h80000400; bus.in_delayslot_i = 1'b0;
    @(posedge clk); #1;
    idle();
    sb.push_back('{name:"int_exccode", exp:32'd0});
    sb.push_back('{name:"int_epc", exp:32'h80000400});
    sb.push_back('{name:"int_exl", exp:32'd1});
    obs.push_back(32'(bus.cause_o[6:2])); obs.push_back(bus.epc_o); obs.push_back(32'(bus.status_o[1]));
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
  endtask

  task automatic test_write_masks();
    exp_t e;
    bus.raddr_i = 5'd13;
    mtc0(5'd12, 32'hFFFFFFFF);
    sb.push_back('{name:"status_mask", exp:32'h0040FF03});
    obs.push_back(bus.status_o);
    mtc0(5'd12, 32'h00000000);
    sb.push_back('{name:"status_clear", exp:32'h00400000});
    obs.push_back(bus.status_o);
    mtc0(5'd13, 32'hFFFFFFFF);
    sb.push_back('{name:"cause_mask", exp:32'h00000300});
    sb.push_back('{name:"cause_read", exp:32'h00000300});
    obs.push_back(bus.cause_o); obs.push_back(bus.rdata_o);
    @(negedge clk);
    bus.int_i = 6'b101011;
    @(posedge clk); #1;
    bus.int_i = 6'd0;
    sb.push_back('{name:"cause_int_sample", exp:32'h0000AF00});
    obs.push_back(bus.cause_o);
    mtc0(5'd13, 32'h00000000);
    mtc0(5'd8, 32'h12345678);
    bus.raddr_i = 5'd8;
    #1;
    sb.push_back('{name:"badvaddr_ro", exp:32'h80001001});
    obs.push_back(bus.rdata_o);
    mtc0(5'd15, 32'hFFFFFFFF);
    bus.raddr_i = 5'd15;
    #1;
    sb.push_back('{name:"prid_ro", exp:PRID_VALUE});
    obs.push_back(bus.rdata_o);
    bus.raddr_i = 5'd16;
    #1;
    sb.push_back('{name:"config_rd", exp:CONFIG_VALUE});
    obs.push_back(bus.rdata_o);
    bus.raddr_i = 5'd5;
    #1;
    sb.push_back('{name:"unmapped_rd", exp:32'd0});
    obs.push_back(bus.rdata_o);
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
  endtask

  task automatic test_timer();
    exp_t e;
    int n;
    bus.raddr_i = 5'd9;
    mtc0(5'd9, 32'd0);
    sb.push_back('{name:"count_write", exp:32'd0});
    obs.push_back(bus.rdata_o);
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    sb.push_back('{name:"count_rewrite", exp:32'd0});
    obs.push_back(bus.rdata_o);
    n = 0;
    while (n < 30 && bus.timer_int_o !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    sb.push_back('{name:"timer_rise_window", exp:32'd1});
    obs.push_back(32'(n >= 9 && n <= 12));
    @(posedge clk); #1;
    sb.push_back('{name:"timer_cause15", exp:32'd1});
    obs.push_back(32'(bus.cause_o[15]));
    mtc0(5'd11, 32'h7FFFFFFF);
    sb.push_back('{name:"timer_clear", exp:32'd0});
    obs.push_back(32'(bus.timer_int_o));
    @(posedge clk); #1;
    sb.push_back('{name:"cause15_clear", exp:32'd0});
    obs.push_back(32'(bus.cause_o[15]));
    // Compare write lands on the same edge that would set the interrupt.
    mtc0(5'd11, 32'h30);
    mtc0(5'd9, 32'h30);
    sb.push_back('{name:"count_0x30", exp:32'h30});
    obs.push_back(bus.rdata_o);
    mtc0(5'd11, 32'h30);
    sb.push_back('{name:"timer_clear_priority", exp:32'd0});
    obs.push_back(32'(bus.timer_int_o));
    mtc0(5'd11, 32'd0);
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    bus.excepttype_i = 32'h8; bus.pc_i = 32'hA0000000;
    bus.we_i = 1'b1; bus.waddr_i = 5'd12; bus.wdata_i = 32'h0;
    @(posedge clk); #1;
    sb.push_back('{name:"b2b_status", exp:32'h00400002});
    sb.push_back('{name:"b2b_epc1", exp:32'hA0000000});
    obs.push_back(bus.status_o); obs.push_back(bus.epc_o);
    @(negedge clk);
    idle();
    bus.excepttype_i = 32'h9; bus.pc_i = 32'hA0000100;
    @(posedge clk); #1;
    sb.push_back('{name:"b2b_epc2", exp:32'hA0000000});
    sb.push_back('{name:"b2b_exccode2", exp:32'd9});
    obs.push_back(bus.epc_o); obs.push_back(32'(bus.cause_o[6:2]));
    @(negedge clk);
    idle();
    bus.excepttype_i = 32'he;
    #1;
    sb.push_back('{name:"b2b_eret_newpc", exp:32'hA0000000});
    obs.push_back(bus.newpc_o);
    @(posedge clk); #1;
    sb.push_back('{name:"b2b_eret_exl", exp:32'd0});
    obs.push_back(32'(bus.status_o[1]));
    @(negedge clk);
    idle();
    bus.excepttype_i = 32'h5; bus.pc_i = 32'h80000800; bus.bad_addr_i = 32'h80000803;
    bus.we_i = 1'b1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h22222220;
    bus.raddr_i = 5'd8;
    @(posedge clk); #1;
    idle();
    sb.push_back('{name:"b2b_ades_epc", exp:32'h80000800});
    sb.push_back('{name:"b2b_ades_exccode", exp:32'd5});
    sb.push_back('{name:"b2b_ades_badvaddr", exp:32'h80000803});
    obs.push_back(bus.epc_o); obs.push_back(32'(bus.cause_o[6:2])); obs.push_back(bus.rdata_o);
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bus.raddr_i = 5'd9;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    sb.push_back('{name:"mid_status", exp:32'h00400000});
    sb.push_back('{name:"mid_epc", exp:32'd0});
    sb.push_back('{name:"mid_cause", exp:32'd0});
    sb.push_back('{name:"mid_count", exp:32'd0});
    obs.push_back(bus.status_o); obs.push_back(bus.epc_o);
    obs.push_back(bus.cause_o); obs.push_back(bus.rdata_o);
    while (obs.size() > 0) begin
      logic [31:0] a = obs.pop_front();
      e = sb.pop_front(); checks++;
      if (a !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, a, e.exp); end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_adel_delayslot();
    test_eret();
    test_ignored_and_int();
    test_write_masks();
    test_timer();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file for the MIPS-32 core. Sits directly downstream of the exception-type encoder in the memory stage.
- Consumes the encoded excepttype each cycle and updates Status, Cause, EPC and BadVAddr accordingly.
- Produces the pipeline flush and redirect PC, and runs the Count/Compare timer.
- Its registered Status and Cause outputs feed back into the encoder for interrupt qualification.

Parameters:
EXC_VECTOR, 32'hBFC00380, redirect PC for every exception other than eret
PRID_VALUE, 32'h00004220, read-only PRId contents
CONFIG_VALUE, 32'h00008000, read-only Config contents

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
we_i  input  1  mtc0 write enable
waddr_i  input  5  mtc0 destination register number
wdata_i  input  32  mtc0 data
raddr_i  input  5  mfc0 source register number
int_i  input  6  hardware interrupt lines, level-sensitive
excepttype_i  input  32  encoded exception from encoder; 0 = none
pc_i  input  32  address of excepting instruction
in_delayslot_i  input  1  excepting instruction is in a branch delay slot
bad_addr_i  input  32  faulting address for AdEL/AdES
rdata_o  output  32  mfc0 read data, combinational
status_o  output  32  registered Status
cause_o  output  32  registered Cause
epc_o  output  32  registered EPC
timer_int_o  output  1  timer interrupt pending
flush_o  output  1  flush pipeline, combinational
newpc_o  output  32  redirect target, valid when flush_o=1

Behaviour:
Register map:
- 8 BadVAddr
- 9 Count
- 11 Compare
- 12 Status
- 13 Cause
- 14 EPC
- 15 PRId
- 16 Config
- rdata_o returns 0 for any other address.

Reset (async, rst=0):
- Status=32'h00400000 (BEV=1).
- Cause, EPC, BadVAddr, Count, Compare = 0.
- timer_int_o=0; internal tick=0.

Write masks:
- Status: bits [15:8] IM, [1] EXL, [0] IE are writable; all other bits hold their reset value.
- Cause: only bits [9:8] (software IP) are writable.
- Count, Compare, EPC: fully writable.
- BadVAddr, PRId, Config: read-only; writes to them are ignored.

Interrupt sampling:
- Every cycle Cause[15:10] <= int_i.
- Exception: Cause[15] <= int_i[5] | timer_int_o.

Timer:
- tick toggles every cycle; Count increments on cycles where tick=1, so it advances once per 2 cycles and wraps 32'hFFFFFFFF -> 0.
- An mtc0 write to Count overrides the increment in that cycle. tick is unaffected.
- timer_int_o sets on the edge after registered Count==Compare with Compare!=0.
- timer_int_o stays set until an mtc0 write to Compare clears it. That clear takes priority over a same-cycle set.

Exceptions (excepttype_i sampled each cycle; codes 0x01 Int, 0x04 AdEL, 0x05 AdES, 0x08 Sys, 0x09 Bp, 0x0a RI, 0x0c Ov, 0x0e eret; any other nonzero value is ignored):
- Non-eret code:
  - flush_o=1; newpc_o=EXC_VECTOR.
  - On the clock edge: Cause[6:2] <= ExcCode, where Int->0 and every other code -> its own low 5 bits; Status.EXL <= 1.
  - If Status.EXL was 0: EPC <= in_delayslot_i ? pc_i-4 : pc_i, and Cause[31] (BD) <= in_delayslot_i.
  - If Status.EXL was already 1: EPC and BD are unchanged.
  - AdEL/AdES additionally load BadVAddr <= bad_addr_i.
- eret (0x0e):
  - flush_o=1; Status.EXL <= 0.
  - newpc_o = EPC. If a same-cycle mtc0 write targets EPC, newpc_o = wdata_i instead (forwarding).
- No exception: flush_o=0; newpc_o=0.
- Latency: flush_o/newpc_o are combinational in the same cycle; register updates are visible on outputs the next cycle.

Simultaneous events:
- mtc0 and exception in the same cycle: exception-driven field updates (EXL, ExcCode, BD, EPC, BadVAddr) win; the write applies to all remaining writable bits.
- Reset mid-operation returns every register to its reset value immediately.

Test Plan:
- Reset -> status_o=32'h00400000; cause_o=0; epc_o=0; flush_o=0; rdata_o@15=PRID_VALUE.
- Syscall: excepttype_i=8, pc_i=32'hBFC00100, in_delayslot_i=0 -> flush_o=1, newpc_o=32'hBFC00380; next cycle EPC=32'hBFC00100, Cause[6:2]=8, EXL=1.
- Delay-slot AdEL: excepttype_i=4, pc_i=32'h80000010, in_delayslot_i=1, bad_addr_i=32'h80001001 -> EPC=32'h8000000C, BD=1, BadVAddr=32'h80001001. A second exception while EXL=1 leaves EPC unchanged.
- eret with same-cycle mtc0 EPC=32'h80000200 -> newpc_o=32'h80000200, EXL cleared next cycle.
- Write Count=0, Compare=5 -> timer_int_o rises about 10 cycles later and cause_o[15]=1. mtc0 to Compare -> timer_int_o=0 next cycle.
- mtc0 Status=32'hFFFFFFFF -> status_o=32'h0040FF03. mtc0 Cause=32'hFFFFFFFF with int_i=0 -> cause_o[9:8]=2'b11 and other writable-by-software bits remain 0.
